if_align_buffer: RTL and testbench

- Sits between the icache response path and the pre-IF compressed-instruction expander.
- Issues word-aligned fetch requests and collects 32-bit fetch words into a 3-halfword parcel buffer.
- Emits one whole instruction per handshake with its PC: 16-bit RVC or 32-bit, including 32-bit instructions that straddle a word boundary.
- Handles redirects (flush) to any halfword-aligned PC, including discard of a stale in-flight response.

---
 rtl/if_align_buffer_pkg.sv | 15 +
 rtl/if_parcel_extract.sv | 17 +
 rtl/if_align_buffer.sv | 122 ++++++++++++
 tb/tb_if_align_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_align_buffer_pkg.sv
// Shared widths, the RVI length code and the length check used by the align
// buffer and the compressed-instruction expander.
package if_align_buffer_pkg;

  localparam int XLEN = 32;
  localparam int HW_W = 16;
  localparam int SLOTS = 3;
  localparam logic [1:0] RVI_LEN_CODE = 2'b11;

  // A parcel whose low two bits are 2'b11 begins a 32-bit instruction.
  function automatic logic is_rvi(input logic [HW_W-1:0] hw);
    return (hw[1:0] == RVI_LEN_CODE);
  endfunction

endpackage

// File: rtl/if_parcel_extract.sv
// Forms the instruction word and its length from the two head parcels.
module if_parcel_extract
  import if_align_buffer_pkg::*;
(
  input  logic [HW_W-1:0] slot0,
  input  logic [HW_W-1:0] slot1,
  output logic [XLEN-1:0] inst,
  output logic            is_32
);

  always_comb begin
    is_32 = is_rvi(slot0);
    if (is_32) inst = {slot1, slot0};
    else       inst = {{(XLEN-HW_W){1'b0}}, slot0};
  end

endmodule

// File: rtl/if_align_buffer.sv
// Fetch alignment buffer: one word-aligned request in flight, a three-parcel
// queue, and one whole RVC or 32-bit instruction handed out per handshake.
module if_align_buffer
  import if_align_buffer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic [XLEN-1:0] flush_pc_i,
  output logic            fetch_req_valid_o,
  output logic [XLEN-1:0] fetch_req_addr_o,
  input  logic            fetch_req_ready_i,
  input  logic            fetch_rsp_valid_i,
  input  logic [XLEN-1:0] fetch_rsp_data_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o,
  input  logic            inst_ready_i
);

  logic [SLOTS*HW_W-1:0] parcel_q, parcel_n, shifted;
  logic [1:0]            cnt_q, cnt_n, cnt_base, consumed_n, need;
  logic [2:0]            cnt_sum;
  logic [XLEN-1:0]       head_pc_q, fetch_pc_q;
  logic                  outstanding_q, drop_q, skip_lo_q;
  logic                  is_32, consume, req_fire, rsp_take, append;
  logic                  unused_flush_bit;

  assign unused_flush_bit = flush_pc_i[0];

  if_parcel_extract u_extract (
    .slot0 (parcel_q[HW_W-1:0]),
    .slot1 (parcel_q[2*HW_W-1:HW_W]),
    .inst  (inst_o),
    .is_32 (is_32)
  );

  assign need         = is_32 ? 2'd2 : 2'd1;
  assign inst_valid_o = (cnt_q >= need) && !flush_i;
  assign inst_pc_o    = head_pc_q;
  assign consume      = inst_valid_o && inst_ready_i;
  assign consumed_n   = consume ? need : 2'd0;

  // cnt<=1 keeps room for a full word even if the consumer stalls.
  assign fetch_req_valid_o = !outstanding_q && (cnt_q <= 2'd1) && !flush_i && rst;
  assign fetch_req_addr_o  = fetch_pc_q;
  assign req_fire          = fetch_req_valid_o && fetch_req_ready_i;
  assign rsp_take          = fetch_rsp_valid_i && outstanding_q;
  assign append            = rsp_take && !drop_q;

  always_comb begin
    case (consumed_n)
      2'd1:    shifted = {{HW_W{1'b0}}, parcel_q[SLOTS*HW_W-1:HW_W]};
      2'd2:    shifted = {{(2*HW_W){1'b0}}, parcel_q[SLOTS*HW_W-1:2*HW_W]};
      default: shifted = parcel_q;
    endcase
    parcel_n = shifted;
    cnt_base = cnt_q - consumed_n;
    cnt_sum  = {1'b0, cnt_base};
    if (append) begin
      if (skip_lo_q) begin
        case (cnt_base)
          2'd0:    parcel_n[HW_W-1:0]         = fetch_rsp_data_i[31:16];
          2'd1:    parcel_n[2*HW_W-1:HW_W]    = fetch_rsp_data_i[31:16];
          default: parcel_n[3*HW_W-1:2*HW_W]  = fetch_rsp_data_i[31:16];
        endcase
        cnt_sum = cnt_sum + 3'd1;
      end else begin
        case (cnt_base)
          2'd0:    parcel_n[2*HW_W-1:0]       = fetch_rsp_data_i;
          2'd1:    parcel_n[3*HW_W-1:HW_W]    = fetch_rsp_data_i;
          default: parcel_n[3*HW_W-1:2*HW_W]  = fetch_rsp_data_i[15:0];
        endcase
        cnt_sum = cnt_sum + 3'd2;
      end
    end
    cnt_n = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      parcel_q      <= '0;
      cnt_q         <= 2'd0;
      head_pc_q     <= RESET_PC;
      fetch_pc_q    <= {RESET_PC[XLEN-1:2], 2'b00};
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      skip_lo_q     <= RESET_PC[1];
    end else if (flush_i) begin
      cnt_q      <= 2'd0;
      head_pc_q  <= {flush_pc_i[XLEN-1:1], 1'b0};
      fetch_pc_q <= {flush_pc_i[XLEN-1:2], 2'b00};
      skip_lo_q  <= flush_pc_i[1];
      // A response landing with the flush is simply dropped; otherwise mark
      // the one still in flight as stale.
      if (outstanding_q) begin
        if (fetch_rsp_valid_i) begin
          outstanding_q <= 1'b0;
          drop_q        <= 1'b0;
        end else begin
          drop_q <= 1'b1;
        end
      end
    end else begin
      parcel_q <= parcel_n;
      cnt_q    <= cnt_n;
      if (consume) head_pc_q <= head_pc_q + (is_32 ? 32'd4 : 32'd2);
      if (req_fire) begin
        outstanding_q <= 1'b1;
        fetch_pc_q    <= fetch_pc_q + 32'd4;
      end
      if (rsp_take) begin
        outstanding_q <= 1'b0;
        if (drop_q)         drop_q    <= 1'b0;
        else if (skip_lo_q) skip_lo_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_align_buffer.sv
// Directed bench for if_align_buffer: aligned, straddling, flushed, stalled
// and reset-interrupted fetch sequences with hand-computed expectations.
module tb_if_align_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        fetch_req_valid_o;
  logic [31:0] fetch_req_addr_o;
  logic        fetch_req_ready_i = 1'b0;
  logic        fetch_rsp_valid_i = 1'b0;
  logic [31:0] fetch_rsp_data_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  if_align_buffer #(.RESET_PC(32'h8000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .flush_i           (flush_i),
    .flush_pc_i        (flush_pc_i),
    .fetch_req_valid_o (fetch_req_valid_o),
    .fetch_req_addr_o  (fetch_req_addr_o),
    .fetch_req_ready_i (fetch_req_ready_i),
    .fetch_rsp_valid_i (fetch_rsp_valid_i),
    .fetch_rsp_data_i  (fetch_rsp_data_i),
    .inst_valid_o      (inst_valid_o),
    .inst_o            (inst_o),
    .inst_pc_o         (inst_pc_o),
    .inst_ready_i      (inst_ready_i)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush_i = 1'b0;
    fetch_req_ready_i = 1'b0;
    fetch_rsp_valid_i = 1'b0;
    inst_ready_i = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  // Waits for a request, checks its address, accepts it, then returns data.
  task automatic fetch_word(input logic [31:0] addr, input logic [31:0] data, input string tag);
    int n = 0;
    #1;
    while (!fetch_req_valid_o && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk({tag, "_req_v"}, {31'b0, fetch_req_valid_o}, 32'd1);
    chk({tag, "_req_a"}, fetch_req_addr_o, addr);
    fetch_req_ready_i = 1'b1;
    cyc();
    fetch_req_ready_i = 1'b0;
    fetch_rsp_valid_i = 1'b1;
    fetch_rsp_data_i  = data;
    cyc();
    fetch_rsp_valid_i = 1'b0;
  endtask

  // Waits for an instruction, checks it, then consumes it for one cycle.
  task automatic expect_inst(input logic [31:0] pc, input logic [31:0] ins, input string tag);
    int n = 0;
    #1;
    while (!inst_valid_o && n < 20) begin
      cyc();
      #1;
      n++;
    end
    chk({tag, "_v"},   {31'b0, inst_valid_o}, 32'd1);
    chk({tag, "_pc"},  inst_pc_o, pc);
    chk({tag, "_ins"}, inst_o, ins);
    inst_ready_i = 1'b1;
    cyc();
    inst_ready_i = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held low
    cyc();
    #1;
    chk("rst_inst_v", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst",   inst_o, 32'h0);
    chk("rst_pc",     inst_pc_o, 32'h8000_0000);
    chk("rst_req_v",  {31'b0, fetch_req_valid_o}, 32'd0);
    cyc();
    rst = 1'b1;

    // Aligned words: one 32-bit, then two RVC
    fetch_word(32'h8000_0000, 32'h0013_0513, "a_w0");
    expect_inst(32'h8000_0000, 32'h0013_0513, "a_i0");
    fetch_word(32'h8000_0004, 32'h4501_4505, "a_w1");
    expect_inst(32'h8000_0004, 32'h0000_4505, "a_i1");
    expect_inst(32'h8000_0006, 32'h0000_4501, "a_i2");

    // 32-bit instruction straddling a word boundary
    do_reset();
    fetch_word(32'h8000_0000, 32'h0513_4505, "s_w0");
    expect_inst(32'h8000_0000, 32'h0000_4505, "s_i0");
    #1;
    chk("s_half_v", {31'b0, inst_valid_o}, 32'd0);
    chk("s_half_req", {31'b0, fetch_req_valid_o}, 32'd1);
    fetch_word(32'h8000_0004, 32'h4501_0013, "s_w1");
    expect_inst(32'h8000_0002, 32'h0013_0513, "s_i1");
    expect_inst(32'h8000_0006, 32'h0000_4501, "s_i2");

    // Flush to a half-word target while a request is in flight
    do_reset();
    #1;
    chk("f_req_a0", fetch_req_addr_o, 32'h8000_0000);
    fetch_req_ready_i = 1'b1;
    cyc();
    fetch_req_ready_i = 1'b0;
    flush_i = 1'b1;
    flush_pc_i = 32'h8000_0102;
    #1;
    chk("f_req_during", {31'b0, fetch_req_valid_o}, 32'd0);
    cyc();
    flush_i = 1'b0;
    #1;
    chk("f_req_stale", {31'b0, fetch_req_valid_o}, 32'd0);
    fetch_rsp_valid_i = 1'b1;
    fetch_rsp_data_i  = 32'hDEAD_BEEF;
    cyc();
    fetch_rsp_valid_i = 1'b0;
    #1;
    chk("f_dropped_v", {31'b0, inst_valid_o}, 32'd0);
    fetch_word(32'h8000_0100, 32'h4505_1111, "f_w0");
    expect_inst(32'h8000_0102, 32'h0000_4505, "f_i0");

    // Flush coinciding with a response and a ready consumer
    do_reset();
    fetch_word(32'h8000_0000, 32'h4501_4505, "c_w0");
    expect_inst(32'h8000_0000, 32'h0000_4505, "c_i0");
    #1;
    chk("c_req_a1", fetch_req_addr_o, 32'h8000_0004);
    fetch_req_ready_i = 1'b1;
    cyc();
    fetch_req_ready_i = 1'b0;
    flush_i = 1'b1;
    flush_pc_i = 32'h8000_0206;
    fetch_rsp_valid_i = 1'b1;
    fetch_rsp_data_i  = 32'h1234_5678;
    inst_ready_i = 1'b1;
    #1;
    chk("c_flush_v", {31'b0, inst_valid_o}, 32'd0);
    chk("c_flush_req", {31'b0, fetch_req_valid_o}, 32'd0);
    cyc();
    flush_i = 1'b0;
    fetch_rsp_valid_i = 1'b0;
    inst_ready_i = 1'b0;
    #1;
    chk("c_post_v",   {31'b0, inst_valid_o}, 32'd0);
    chk("c_post_pc",  inst_pc_o, 32'h8000_0206);
    chk("c_post_req", {31'b0, fetch_req_valid_o}, 32'd1);
    chk("c_post_a",   fetch_req_addr_o, 32'h8000_0204);
    fetch_word(32'h8000_0204, 32'h4501_AAAA, "c_w1");
    expect_inst(32'h8000_0206, 32'h0000_4501, "c_i1");

    // Full buffer with the consumer stalled for ten cycles
    do_reset();
    fetch_word(32'h8000_0000, 32'h4501_4505, "b_w0");
    expect_inst(32'h8000_0000, 32'h0000_4505, "b_i0");
    fetch_word(32'h8000_0004, 32'h4509_450D, "b_w1");
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("b_hold_req", {31'b0, fetch_req_valid_o}, 32'd0);
      chk("b_hold_v",   {31'b0, inst_valid_o}, 32'd1);
      chk("b_hold_ins", inst_o, 32'h0000_4501);
      chk("b_hold_pc",  inst_pc_o, 32'h8000_0002);
      cyc();
    end
    expect_inst(32'h8000_0002, 32'h0000_4501, "b_i1");
    expect_inst(32'h8000_0004, 32'h0000_450D, "b_i2");
    expect_inst(32'h8000_0006, 32'h0000_4509, "b_i3");

    // Reset while a request is outstanding; late response must be ignored
    #1;
    chk("r_req_a", fetch_req_addr_o, 32'h8000_0008);
    fetch_req_ready_i = 1'b1;
    cyc();
    fetch_req_ready_i = 1'b0;
    rst = 1'b0;
    cyc();
    #1;
    chk("r_inst_v", {31'b0, inst_valid_o}, 32'd0);
    chk("r_inst",   inst_o, 32'h0);
    chk("r_pc",     inst_pc_o, 32'h8000_0000);
    chk("r_req_v0", {31'b0, fetch_req_valid_o}, 32'd0);
    rst = 1'b1;
    fetch_rsp_valid_i = 1'b1;
    fetch_rsp_data_i  = 32'h4505_4505;
    #1;
    chk("r_req_v1", {31'b0, fetch_req_valid_o}, 32'd1);
    chk("r_req_a1", fetch_req_addr_o, 32'h8000_0000);
    cyc();
    fetch_rsp_valid_i = 1'b0;
    #1;
    chk("r_late_v", {31'b0, inst_valid_o}, 32'd0);
    fetch_word(32'h8000_0000, 32'h0000_4505, "r_w0");
    expect_inst(32'h8000_0000, 32'h0000_4505, "r_i0");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
